conv_result_streamer: RTL

// Downstream stage of convolve: captures the flattened convolution result when
// is_completed rises and streams it out one 16-bit sample per handshake
// (valid/ready), index 0 first. Frees convolve for its next load while the

---
 rtl/conv_result_streamer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: snapshots the flattened convolve result on the rising edge of
// is_completed, then streams it out one DATA_W sample per valid/ready transfer.
// Optional feature macro: CONV_ROUND_SHIFT_EN (round, arithmetic shift by SHIFT, saturate).
module conv_result_streamer #(
  parameter int unsigned LEN           = 19,
  parameter int unsigned SIGNAL_LENGTH = 2400,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned IDX_W         = 12,
  parameter int unsigned SHIFT         = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [(LEN+SIGNAL_LENGTH+1)*DATA_W:0]          conv_result,
  input  logic                                           is_completed,
  output logic [DATA_W-1:0]                              out_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [IDX_W-1:0]                               out_index,
  output logic                                           out_last,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           overrun
);

  localparam int unsigned      NOut    = LEN + SIGNAL_LENGTH + 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NOut - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              prev_q;
  logic              seen_low_q, seen_low_d;
  logic              trigger;
  logic              capture;
  logic [DATA_W-1:0] shadow_q [NOut];
  logic [DATA_W-1:0] raw_sample;
  logic [DATA_W-1:0] proc_sample;

  // Top bit of conv_result carries nothing.
  logic unused_msb;
  assign unused_msb = conv_result[NOut*DATA_W];

  // A level that was already high when reset released must not count as a new result.
  assign trigger    = is_completed & ~prev_q & seen_low_q;
  assign seen_low_d = seen_low_q | ~is_completed;

  // Edge-detect history and control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      prev_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      prev_q     <= is_completed;
      seen_low_q <= seen_low_d;
    end
  end

  // Shadow buffer, deliberately not reset; only written when a new result is accepted.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < int'(NOut); k++) begin
        shadow_q[k] <= conv_result[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: capture in idle, one load cycle, then one sample per accepted transfer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    capture   = 1'b0;
    overrun_d = overrun_q | (trigger & (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        idx_d   = '0;
        state_d = StStream;
      end
      StStream: begin
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign raw_sample = shadow_q[idx_q];

`ifdef CONV_ROUND_SHIFT_EN
  localparam logic signed [DATA_W:0] RndBias =
      (SHIFT == 0) ? '0 : ((DATA_W+1)'(1) << (SHIFT - 1));
  localparam logic signed [DATA_W:0] SatMax  = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] SatMin  = {2'b11, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0] ext_s;
  logic signed [DATA_W:0] rnd_s;

  // Round half up, arithmetic shift in DATA_W+1 bits, then clamp to the DATA_W range.
  always_comb begin
    ext_s = {raw_sample[DATA_W-1], raw_sample};
    rnd_s = (ext_s + RndBias) >>> SHIFT;
    if (rnd_s > SatMax) begin
      proc_sample = SatMax[DATA_W-1:0];
    end else if (rnd_s < SatMin) begin
      proc_sample = SatMin[DATA_W-1:0];
    end else begin
      proc_sample = rnd_s[DATA_W-1:0];
    end
  end
`else
  logic unused_shift;
  assign unused_shift = ^SHIFT;
  assign proc_sample  = raw_sample;
`endif

  assign out_valid = (state_q == StStream);
  assign out_index = idx_q;
  assign out_last  = out_valid && (idx_q == LastIdx);
  assign out_data  = out_valid ? proc_sample : '0;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
